// File: rtl/console_pkg.sv
// console_pkg: shared constants, state encoding and address helper for the
// VGA text console controller.
//   COLS/ROWS  : screen geometry in characters
//   BLANK      : fill character used for clear, scroll and backspace
//   SC_*       : PS/2 set-2 scancode bytes with control meaning
//   state_t    : console_ctrl FSM states
//   cell_addr  : row/column to linear character RAM address
package console_pkg;

    localparam int COLS         = 70;
    localparam int ROWS         = 30;
    localparam int CELLS        = COLS * ROWS;
    localparam int SCROLL_CELLS = (ROWS - 1) * COLS;

    localparam logic [7:0] BLANK    = 8'h20;
    localparam logic [7:0] SC_BREAK = 8'hF0;
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_ENTER = 8'h5A;
    localparam logic [7:0] SC_BKSP  = 8'h66;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_IDLE,
        ST_WRITE,
        ST_SCROLL_RD,
        ST_SCROLL_WR,
        ST_SCROLL_BLANK
    } state_t;

    function automatic logic [11:0] cell_addr(input logic [4:0] row, input logic [6:0] col);
        return 12'(row) * 12'(COLS) + 12'(col);
    endfunction

endpackage

// File: rtl/ps2_scan_decode.sv
// ps2_scan_decode: combinational PS/2 set-2 make code to ASCII translation.
//   code  in  8  make code byte
//   ascii out 8  lowercase letters, digits, space (0x29) and unshifted
//                punctuation; 0x00 for any code without a printable mapping
module ps2_scan_decode (
    input  logic [7:0] code,
    output logic [7:0] ascii
);

    always_comb begin
        ascii = 8'h00;
        case (code)
            8'h1C: ascii = "a";
            8'h32: ascii = "b";
            8'h21: ascii = "c";
            8'h23: ascii = "d";
            8'h24: ascii = "e";
            8'h2B: ascii = "f";
            8'h34: ascii = "g";
            8'h33: ascii = "h";
            8'h43: ascii = "i";
            8'h3B: ascii = "j";
            8'h42: ascii = "k";
            8'h4B: ascii = "l";
            8'h3A: ascii = "m";
            8'h31: ascii = "n";
            8'h44: ascii = "o";
            8'h4D: ascii = "p";
            8'h15: ascii = "q";
            8'h2D: ascii = "r";
            8'h1B: ascii = "s";
            8'h2C: ascii = "t";
            8'h3C: ascii = "u";
            8'h2A: ascii = "v";
            8'h1D: ascii = "w";
            8'h22: ascii = "x";
            8'h35: ascii = "y";
            8'h1A: ascii = "z";
            8'h45: ascii = "0";
            8'h16: ascii = "1";
            8'h1E: ascii = "2";
            8'h26: ascii = "3";
            8'h25: ascii = "4";
            8'h2E: ascii = "5";
            8'h36: ascii = "6";
            8'h3D: ascii = "7";
            8'h3E: ascii = "8";
            8'h46: ascii = "9";
            8'h29: ascii = " ";
            8'h4E: ascii = "-";
            8'h55: ascii = "=";
            8'h54: ascii = "[";
            8'h5B: ascii = "]";
            8'h5D: ascii = 8'h5C;
            8'h4C: ascii = ";";
            8'h52: ascii = "'";
            8'h41: ascii = ",";
            8'h49: ascii = ".";
            8'h4A: ascii = "/";
            8'h0E: ascii = 8'h60;
            default: ascii = 8'h00;
        endcase
    end

endmodule

// File: rtl/console_ctrl.sv
// console_ctrl: sequencing controller for the VGA text console.
// Decodes PS/2 set-2 bytes into characters, owns the single port of the
// COLS x ROWS character RAM, tracks the cursor, clears the screen after
// reset and scrolls the buffer up one row when output runs off the bottom.
//   clk, rst      clock; asynchronous active-high reset
//   key_valid     one-cycle strobe qualifying key_code
//   key_code      raw PS/2 byte (make, 0xF0 break, 0xE0 extended)
//   ram_rdata     RAM read data, valid the cycle after ram_addr
//   ram_addr      RAM address = row*COLS + col
//   ram_wdata     RAM write data
//   ram_we        RAM write enable
//   cursor_col    current column 0..COLS-1
//   cursor_row    current row 0..ROWS-1
//   busy          high whenever the FSM is not IDLE
//   key_overflow  one-cycle pulse when an incoming byte is dropped
module console_ctrl
    import console_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        key_valid,
    input  logic [7:0]  key_code,
    input  logic [7:0]  ram_rdata,
    output logic [11:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_we,
    output logic [6:0]  cursor_col,
    output logic [4:0]  cursor_row,
    output logic        busy,
    output logic        key_overflow
);

    localparam logic [6:0]  COL_LAST    = 7'(COLS - 1);
    localparam logic [4:0]  ROW_LAST    = 5'(ROWS - 1);
    localparam logic [11:0] ADDR_LAST   = 12'(CELLS - 1);
    localparam logic [11:0] SCROLL_LAST = 12'(SCROLL_CELLS - 1);
    localparam logic [11:0] BLANK_BASE  = 12'(SCROLL_CELLS);

    state_t      state;
    logic [11:0] cnt;
    logic [11:0] addr_q;
    logic [7:0]  wdata_q;
    logic        we_q;
    logic        hold_valid;
    logic [7:0]  hold_code;
    logic        brk_flag;
    logic        ext_flag;
    logic        wr_bksp;

    logic        dec_go;
    logic [7:0]  dec_code;
    logic [7:0]  dec_ascii;

    // A held byte always has priority over a fresh strobe so bytes are
    // decoded in arrival order.
    always_comb begin
        dec_go   = 1'b0;
        dec_code = key_code;
        if (state == ST_IDLE) begin
            if (hold_valid) begin
                dec_go   = 1'b1;
                dec_code = hold_code;
            end else if (key_valid) begin
                dec_go   = 1'b1;
            end
        end
    end

    ps2_scan_decode u_decode (
        .code  (dec_code),
        .ascii (dec_ascii)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= ST_CLEAR;
            cnt          <= '0;
            addr_q       <= '0;
            wdata_q      <= BLANK;
            we_q         <= 1'b0;
            hold_valid   <= 1'b0;
            hold_code    <= '0;
            brk_flag     <= 1'b0;
            ext_flag     <= 1'b0;
            wr_bksp      <= 1'b0;
            cursor_col   <= '0;
            cursor_row   <= '0;
            key_overflow <= 1'b0;
        end else begin
            key_overflow <= 1'b0;

            // One-entry hold buffer: absorbs a byte while busy, and refills
            // from a simultaneous strobe while the held byte is decoded.
            if (state != ST_IDLE) begin
                if (key_valid) begin
                    if (!hold_valid) begin
                        hold_valid <= 1'b1;
                        hold_code  <= key_code;
                    end else begin
                        key_overflow <= 1'b1;
                    end
                end
            end else if (hold_valid) begin
                if (key_valid) begin
                    hold_code <= key_code;
                end else begin
                    hold_valid <= 1'b0;
                end
            end

            case (state)
                ST_CLEAR: begin
                    if (cnt == ADDR_LAST) begin
                        cnt   <= '0;
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt + 12'd1;
                    end
                end

                ST_IDLE: begin
                    if (dec_go) begin
                        if (dec_code == SC_BREAK) begin
                            brk_flag <= 1'b1;
                        end else if (dec_code == SC_EXT) begin
                            ext_flag <= 1'b1;
                        end else if (brk_flag || ext_flag) begin
                            // Byte belongs to a release or extended sequence.
                            brk_flag <= 1'b0;
                            ext_flag <= 1'b0;
                        end else if (dec_code == SC_ENTER) begin
                            cursor_col <= '0;
                            if (cursor_row != ROW_LAST) begin
                                cursor_row <= cursor_row + 5'd1;
                            end else begin
                                state  <= ST_SCROLL_RD;
                                cnt    <= '0;
                                addr_q <= 12'(COLS);
                                we_q   <= 1'b0;
                            end
                        end else if (dec_code == SC_BKSP) begin
                            if (cursor_col != 7'd0) begin
                                addr_q  <= cell_addr(cursor_row, cursor_col - 7'd1);
                                wdata_q <= BLANK;
                                we_q    <= 1'b1;
                                wr_bksp <= 1'b1;
                                state   <= ST_WRITE;
                            end
                        end else if (dec_ascii != 8'h00) begin
                            addr_q  <= cell_addr(cursor_row, cursor_col);
                            wdata_q <= dec_ascii;
                            we_q    <= 1'b1;
                            wr_bksp <= 1'b0;
                            state   <= ST_WRITE;
                        end
                    end
                end

                // Cursor moves only after the character has been written.
                ST_WRITE: begin
                    we_q  <= 1'b0;
                    state <= ST_IDLE;
                    if (wr_bksp) begin
                        cursor_col <= cursor_col - 7'd1;
                    end else if (cursor_col == COL_LAST) begin
                        cursor_col <= '0;
                        if (cursor_row != ROW_LAST) begin
                            cursor_row <= cursor_row + 5'd1;
                        end else begin
                            state  <= ST_SCROLL_RD;
                            cnt    <= '0;
                            addr_q <= 12'(COLS);
                        end
                    end else begin
                        cursor_col <= cursor_col + 7'd1;
                    end
                end

                // Read cell a+COLS; its data arrives during SCROLL_WR.
                ST_SCROLL_RD: begin
                    state  <= ST_SCROLL_WR;
                    addr_q <= cnt;
                    we_q   <= 1'b1;
                end

                ST_SCROLL_WR: begin
                    if (cnt == SCROLL_LAST) begin
                        state   <= ST_SCROLL_BLANK;
                        addr_q  <= BLANK_BASE;
                        wdata_q <= BLANK;
                        we_q    <= 1'b1;
                    end else begin
                        state  <= ST_SCROLL_RD;
                        cnt    <= cnt + 12'd1;
                        addr_q <= cnt + 12'(COLS + 1);
                        we_q   <= 1'b0;
                    end
                end

                ST_SCROLL_BLANK: begin
                    if (addr_q == ADDR_LAST) begin
                        state <= ST_IDLE;
                        we_q  <= 1'b0;
                    end else begin
                        addr_q <= addr_q + 12'd1;
                    end
                end

                default: state <= ST_CLEAR;
            endcase
        end
    end

    // CLEAR drives the port straight from its counter so the first blank
    // lands in the very first cycle after reset release; SCROLL_WR forwards
    // the registered RAM read data into the write.
    always_comb begin
        ram_addr  = addr_q;
        ram_wdata = wdata_q;
        ram_we    = we_q;
        case (state)
            ST_CLEAR: begin
                ram_addr  = cnt;
                ram_wdata = BLANK;
                ram_we    = ~rst;
            end
            ST_SCROLL_WR: ram_wdata = ram_rdata;
            default: ;
        endcase
    end

    assign busy = (state != ST_IDLE);

endmodule
